hazard_ctrl: RTL and testbench

Parametrised hazard/stall controller for the 5-stage MIPS pipeline; successor to the single-cycle load-use/jump/branch stall logic. Generates PC write-enable, IF/ID write-enable and IF/ID flush controls, and adds three things the older logic lacked: multi-cycle load-use stalls for slow memory, a multiply/divide busy interlock, and a saturating stall-cycle performance counter. It sits beside the IF/ID and ID/EX pipeline registers and is sampled every cycle.

---
 rtl/hazard_ctrl.sv | 144 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// Hazard/stall controller for the 5-stage MIPS pipeline: multi-cycle load-use
// stalls, multiply/divide busy interlock, jump/branch flushes and a stall counter.
module hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int MDU_LAT  = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs_id,
    input  logic [4:0]       rt_id,
    input  logic [5:0]       opcode_id,
    input  logic [5:0]       funct_id,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_mdu_start,
    input  logic             ex_branch_taken,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_flush,
    output logic             id_flush,
    output logic             mdu_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int MDU_W  = $clog2(MDU_LAT + 1);
    localparam int WAIT_W = 3;
    localparam bit MULTI_LOAD = (LOAD_LAT > 1);
    localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(LOAD_LAT - 1);
    localparam logic [WAIT_W-1:0] WAIT_ONE  = {{(WAIT_W-1){1'b0}}, 1'b1};
    localparam logic [MDU_W-1:0]  MDU_INIT  = MDU_W'(MDU_LAT);
    localparam logic [MDU_W-1:0]  MDU_ONE   = {{(MDU_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    // control bundle order: {pc_write, if_id_write, if_flush, id_flush}
    localparam logic [3:0] CTL_RESET  = 4'b0011;
    localparam logic [3:0] CTL_BRANCH = 4'b1111;
    localparam logic [3:0] CTL_STALL  = 4'b0001;
    localparam logic [3:0] CTL_JUMP   = 4'b1110;
    localparam logic [3:0] CTL_NORM   = 4'b1100;

    typedef enum logic [0:0] {IDLE = 1'b0, LWAIT = 1'b1} state_t;

    state_t             state_r;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [MDU_W-1:0]   mdu_cnt_r;
    logic [CNT_W-1:0]   stall_cnt_r;

    logic       load_haz_s;
    logic       mdu_busy_s;
    logic       mdu_use_s;
    logic       jump_id_s;
    logic       stall_s;
    logic [3:0] ctl_s;

    // Hazard detection and prioritised pipeline control; reset forces an empty pipeline.
    always_comb begin
        load_haz_s = ex_mem_read && (ex_rt != 5'd0) &&
                     ((rs_id == ex_rt) || (rt_id == ex_rt));
        mdu_busy_s = (mdu_cnt_r != {MDU_W{1'b0}}) || ex_mdu_start;
        mdu_use_s  = (opcode_id == 6'd0) &&
                     ((funct_id == 6'b010000) || (funct_id == 6'b010010) ||
                      (funct_id[5:2] == 4'b0110));
        jump_id_s  = (opcode_id == 6'b000010) || (opcode_id == 6'b000011) ||
                     ((opcode_id == 6'd0) &&
                      ((funct_id == 6'b001000) || (funct_id == 6'b001001)));
        stall_s    = ((state_r == IDLE) && load_haz_s) || (state_r == LWAIT);
        ctl_s      = CTL_NORM;
        if (!reset) begin
            ctl_s = CTL_RESET;
        end else if (ex_branch_taken) begin
            ctl_s = CTL_BRANCH;
        end else if (stall_s || (mdu_busy_s && mdu_use_s)) begin
            ctl_s = CTL_STALL;
        end else if (jump_id_s) begin
            ctl_s = CTL_JUMP;
        end else begin
            ctl_s = CTL_NORM;
        end
    end

    assign {pc_write, if_id_write, if_flush, id_flush} = ctl_s;
    assign mdu_busy  = reset && mdu_busy_s;
    assign stall_cnt = stall_cnt_r;

    // Load-wait FSM: the IDLE hazard cycle plus LOAD_LAT-1 LWAIT cycles give LOAD_LAT stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r    <= IDLE;
            wait_cnt_r <= {WAIT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (MULTI_LOAD && load_haz_s && !ex_branch_taken) begin
                        state_r    <= LWAIT;
                        wait_cnt_r <= WAIT_INIT;
                    end else begin
                        state_r    <= IDLE;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end
                end
                LWAIT: begin
                    if (ex_branch_taken || (wait_cnt_r <= WAIT_ONE)) begin
                        state_r    <= IDLE;
                        wait_cnt_r <= {WAIT_W{1'b0}};
                    end else begin
                        state_r    <= LWAIT;
                        wait_cnt_r <= wait_cnt_r - WAIT_ONE;
                    end
                end
                default: begin
                    state_r    <= IDLE;
                    wait_cnt_r <= {WAIT_W{1'b0}};
                end
            endcase
        end
    end

    // MDU latency counter; a new start restarts it and branch flushes leave it alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mdu_cnt_r <= {MDU_W{1'b0}};
        end else if (ex_mdu_start) begin
            mdu_cnt_r <= MDU_INIT;
        end else if (mdu_cnt_r != {MDU_W{1'b0}}) begin
            mdu_cnt_r <= mdu_cnt_r - MDU_ONE;
        end else begin
            mdu_cnt_r <= mdu_cnt_r;
        end
    end

    // Saturating count of cycles in which the PC was held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (!ctl_s[3] && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: instance a (LOAD_LAT=1, CNT_W=16) and
// instance b (LOAD_LAT=3, CNT_W=4) share one stimulus stream.
module tb_hazard_ctrl;

    localparam logic [3:0] RST = 4'b0011;
    localparam logic [3:0] BR  = 4'b1111;
    localparam logic [3:0] STL = 4'b0001;
    localparam logic [3:0] JMP = 4'b1110;
    localparam logic [3:0] NRM = 4'b1100;

    logic       clk = 1'b0;
    logic       reset;
    logic [4:0] rs_id, rt_id, ex_rt;
    logic [5:0] opcode_id, funct_id;
    logic       ex_mem_read, ex_mdu_start, ex_branch_taken;

    logic        pcw_a, ifw_a, iff_a, idf_a, busy_a;
    logic [15:0] cnt_a;
    logic        pcw_b, ifw_b, iff_b, idf_b, busy_b;
    logic [3:0]  cnt_b;

    int n_cmp  = 0;
    int n_fail = 0;

    wire [3:0] ctl_a = {pcw_a, ifw_a, iff_a, idf_a};
    wire [3:0] ctl_b = {pcw_b, ifw_b, iff_b, idf_b};

    always #5 clk = ~clk;

    hazard_ctrl #(.LOAD_LAT(1), .MDU_LAT(4), .CNT_W(16)) u_a (
        .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
        .opcode_id(opcode_id), .funct_id(funct_id), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_mdu_start(ex_mdu_start), .ex_branch_taken(ex_branch_taken),
        .pc_write(pcw_a), .if_id_write(ifw_a), .if_flush(iff_a), .id_flush(idf_a),
        .mdu_busy(busy_a), .stall_cnt(cnt_a)
    );

    hazard_ctrl #(.LOAD_LAT(3), .MDU_LAT(4), .CNT_W(4)) u_b (
        .clk(clk), .reset(reset), .rs_id(rs_id), .rt_id(rt_id),
        .opcode_id(opcode_id), .funct_id(funct_id), .ex_mem_read(ex_mem_read),
        .ex_rt(ex_rt), .ex_mdu_start(ex_mdu_start), .ex_branch_taken(ex_branch_taken),
        .pc_write(pcw_b), .if_id_write(ifw_b), .if_flush(iff_b), .id_flush(idf_b),
        .mdu_busy(busy_b), .stall_cnt(cnt_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0;
        rs_id = 5'd1; rt_id = 5'd2; ex_rt = 5'd0;
        opcode_id = 6'h08; funct_id = 6'd0;
        ex_mem_read = 1'b0; ex_mdu_start = 1'b0; ex_branch_taken = 1'b0;

        // reset state
        #12;
        chk("rst_ctl_a", 32'(ctl_a), 32'(RST));
        chk("rst_ctl_b", 32'(ctl_b), 32'(RST));
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_busy_b", 32'(busy_b), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        #1;
        chk("norm_a", 32'(ctl_a), 32'(NRM));
        chk("norm_b", 32'(ctl_b), 32'(NRM));

        // load-use hazard: 1 stall on a, 3 on b
        ex_mem_read = 1'b1; ex_rt = 5'd5; rs_id = 5'd5;
        #1;
        chk("lu_c0_a", 32'(ctl_a), 32'(STL));
        chk("lu_c0_b", 32'(ctl_b), 32'(STL));
        tick();
        ex_mem_read = 1'b0;
        #1;
        chk("lu_c1_a", 32'(ctl_a), 32'(NRM));
        chk("lu_cnt_a", 32'(cnt_a), 32'd1);
        chk("lu_c1_b", 32'(ctl_b), 32'(STL));
        tick(); #1;
        chk("lu_c2_b", 32'(ctl_b), 32'(STL));
        tick(); #1;
        chk("lu_c3_b", 32'(ctl_b), 32'(NRM));
        chk("lu_cnt_b", 32'(cnt_b), 32'd3);

        // load into $zero never stalls
        ex_mem_read = 1'b1; ex_rt = 5'd0; rs_id = 5'd0;
        #1;
        chk("zero_a", 32'(ctl_a), 32'(NRM));
        chk("zero_b", 32'(ctl_b), 32'(NRM));
        tick();
        ex_mem_read = 1'b0; rs_id = 5'd1;
        #1;
        chk("zero_cnt_a", 32'(cnt_a), 32'd1);
        chk("zero_cnt_b", 32'(cnt_b), 32'd3);

        // branch taken during the second stall cycle abandons LWAIT
        ex_mem_read = 1'b1; ex_rt = 5'd5; rt_id = 5'd5;
        #1;
        chk("br_c0_b", 32'(ctl_b), 32'(STL));
        tick();
        ex_mem_read = 1'b0; ex_branch_taken = 1'b1; rt_id = 5'd2;
        #1;
        chk("br_c1_a", 32'(ctl_a), 32'(BR));
        chk("br_c1_b", 32'(ctl_b), 32'(BR));
        tick();
        ex_branch_taken = 1'b0;
        #1;
        chk("br_c2_b", 32'(ctl_b), 32'(NRM));
        chk("br_cnt_a", 32'(cnt_a), 32'd2);
        chk("br_cnt_b", 32'(cnt_b), 32'd4);

        // mflo in ID with mult starting: start cycle + 4 stall cycles
        opcode_id = 6'd0; funct_id = 6'b010010; ex_mdu_start = 1'b1;
        #1;
        chk("mdu_c0_b", 32'(ctl_b), 32'(STL));
        chk("mdu_busy0_a", 32'(busy_a), 32'd1);
        tick();
        ex_mdu_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mdu_stall_b", 32'(ctl_b), 32'(STL));
            chk("mdu_busy_b", 32'(busy_b), 32'd1);
            tick();
        end
        #1;
        chk("mdu_rel_b", 32'(ctl_b), 32'(NRM));
        chk("mdu_rel_busy_b", 32'(busy_b), 32'd0);
        chk("mdu_cnt_a", 32'(cnt_a), 32'd7);
        chk("mdu_cnt_b", 32'(cnt_b), 32'd9);

        // jr $31 with no hazard flushes IF
        funct_id = 6'b001000; rs_id = 5'd31;
        #1;
        chk("jr_a", 32'(ctl_a), 32'(JMP));
        chk("jr_b", 32'(ctl_b), 32'(JMP));
        tick();
        // jr held by a load stall flushes only once it advances
        ex_mem_read = 1'b1; ex_rt = 5'd31;
        #1;
        chk("jrs_c0_a", 32'(ctl_a), 32'(STL));
        chk("jrs_c0_b", 32'(ctl_b), 32'(STL));
        tick();
        ex_mem_read = 1'b0;
        #1;
        chk("jrs_c1_a", 32'(ctl_a), 32'(JMP));
        chk("jrs_c1_b", 32'(ctl_b), 32'(STL));
        tick(); #1;
        chk("jrs_c2_b", 32'(ctl_b), 32'(STL));
        tick(); #1;
        chk("jrs_c3_b", 32'(ctl_b), 32'(JMP));
        chk("jrs_cnt_a", 32'(cnt_a), 32'd8);
        chk("jrs_cnt_b", 32'(cnt_b), 32'd12);
        tick();
        opcode_id = 6'b000010; funct_id = 6'd0; rs_id = 5'd1;
        #1;
        chk("j_a", 32'(ctl_a), 32'(JMP));
        tick();

        // 20 back-to-back MDU stalls saturate the 4-bit counter
        opcode_id = 6'd0; funct_id = 6'b010000; ex_mdu_start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
        end
        ex_mdu_start = 1'b0; funct_id = 6'b100000;
        #1;
        chk("sat_ctl_a", 32'(ctl_a), 32'(NRM));
        chk("sat_busy_a", 32'(busy_a), 32'd1);
        chk("sat_cnt_a", 32'(cnt_a), 32'd28);
        chk("sat_cnt_b", 32'(cnt_b), 32'd15);
        for (int i = 0; i < 4; i++) begin
            tick();
        end
        chk("drain_busy_a", 32'(busy_a), 32'd0);

        // asynchronous reset in the middle of LWAIT
        opcode_id = 6'h08; ex_mem_read = 1'b1; ex_rt = 5'd5; rs_id = 5'd5;
        #1;
        chk("ar_c0_b", 32'(ctl_b), 32'(STL));
        tick();
        ex_mem_read = 1'b0;
        #1;
        chk("ar_c1_b", 32'(ctl_b), 32'(STL));
        reset = 1'b0; ex_mdu_start = 1'b1;
        #1;
        chk("ar_ctl_a", 32'(ctl_a), 32'(RST));
        chk("ar_ctl_b", 32'(ctl_b), 32'(RST));
        chk("ar_cnt_a", 32'(cnt_a), 32'd0);
        chk("ar_cnt_b", 32'(cnt_b), 32'd0);
        chk("ar_busy_b", 32'(busy_b), 32'd0);
        tick();
        ex_mdu_start = 1'b0; reset = 1'b1;
        #1;
        chk("ar_rel_b", 32'(ctl_b), 32'(NRM));
        chk("ar_rel_busy_a", 32'(busy_a), 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
